// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bus: pipeline register tags and write enables in; stall, forward
// selects, multiplier status and stall count out. The hazard unit is the slave.
interface hazard_ctrl_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 32
);
  logic [AW-1:0]    rsD, rtD, rsE, rtE;
  logic [AW-1:0]    writeregE, writeregM, writeregW;
  logic             regwriteE, regwriteM, regwriteW;
  logic             memtoregE, memtoregM;
  logic             branchD, multD, hiloreadD, multstartE;
  logic             stallF, stallD, flushE;
  logic             forwardAD, forwardBD;
  logic [1:0]       forwardAE, forwardBE;
  logic             multbusy, multdone;
  logic [CNT_W-1:0] stallcnt;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, multD, hiloreadD, multstartE,
    input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
           multbusy, multdone, stallcnt
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, multD, hiloreadD, multstartE,
    output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
           multbusy, multdone, stallcnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/multiply stalls and
// a multiplier occupancy FSM. Define HAZARD_STALL_CNT_EN to build the stall counter.
module hazard_ctrl #(
  parameter int AW       = 5,
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 32
) (
  input logic         clk,
  input logic         reset_n,
  hazard_ctrl_if.slave hz
);

  localparam int MCW = $clog2(MULT_LAT);
  localparam logic [MCW-1:0] CNT_LOAD = MCW'(MULT_LAT - 32'sd1);
  localparam logic [MCW-1:0] CNT_ONE  = MCW'(32'd1);
  localparam logic [MCW-1:0] CNT_ZERO = {MCW{1'b0}};
  localparam logic [AW-1:0]  REG_ZERO = {AW{1'b0}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mulState_t;

  mulState_t      stateR, stateNext;
  logic [MCW-1:0] cntR, cntNext;
  logic           doneR, doneNext;

  logic       loadUseS, branchS, multS, stallS;
  logic       fwdADS, fwdBDS;
  logic [1:0] fwdAES, fwdBES;

  // Execute-stage mux select: Memory result wins over Writeback; $0 never forwards.
  function automatic logic [1:0] exSel(input logic [AW-1:0] src,
                                       input logic [AW-1:0] wM, input logic rwM,
                                       input logic [AW-1:0] wW, input logic rwW);
    logic [1:0] sel;
    if ((src != REG_ZERO) && rwM && (src == wM)) begin
      sel = 2'b10;
    end else if ((src != REG_ZERO) && rwW && (src == wW)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Multiplier FSM state, latency counter and completion pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateR <= IDLE;
      cntR   <= CNT_ZERO;
      doneR  <= 1'b0;
    end else begin
      stateR <= stateNext;
      cntR   <= cntNext;
      doneR  <= doneNext;
    end
  end

  // Multiplier next state; a start in BUSY is ignored since the stall logic forbids it.
  always_comb begin
    stateNext = stateR;
    cntNext   = cntR;
    doneNext  = 1'b0;
    case (stateR)
      IDLE: begin
        if (hz.multstartE) begin
          stateNext = BUSY;
          cntNext   = CNT_LOAD;
        end else begin
          stateNext = IDLE;
        end
      end
      BUSY: begin
        if (cntR <= CNT_ONE) begin
          stateNext = IDLE;
          cntNext   = CNT_ZERO;
          doneNext  = 1'b1;
        end else begin
          cntNext = cntR - CNT_ONE;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = CNT_ZERO;
      end
    endcase
  end

  // Stall terms and forwarding selects; everything is held quiet while in reset.
  always_comb begin
    loadUseS = 1'b0;
    branchS  = 1'b0;
    multS    = 1'b0;
    stallS   = 1'b0;
    fwdADS   = 1'b0;
    fwdBDS   = 1'b0;
    fwdAES   = 2'b00;
    fwdBES   = 2'b00;
    if (reset_n) begin
      loadUseS = hz.memtoregE && (hz.rtE != REG_ZERO) &&
                 ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
      branchS  = hz.branchD &&
                 ((hz.regwriteE && (hz.writeregE != REG_ZERO) &&
                   ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
                  (hz.memtoregM && (hz.writeregM != REG_ZERO) &&
                   ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
      multS    = (hz.multD || hz.hiloreadD) && ((stateR == BUSY) || hz.multstartE);
      stallS   = loadUseS || branchS || multS;
      fwdADS   = (hz.rsD != REG_ZERO) && hz.regwriteM && !hz.memtoregM &&
                 (hz.rsD == hz.writeregM);
      fwdBDS   = (hz.rtD != REG_ZERO) && hz.regwriteM && !hz.memtoregM &&
                 (hz.rtD == hz.writeregM);
      fwdAES   = exSel(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
      fwdBES   = exSel(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
    end else begin
      stallS = 1'b0;
    end
  end

  assign hz.stallF    = stallS;
  assign hz.stallD    = stallS;
  assign hz.flushE    = stallS;
  assign hz.forwardAD = fwdADS;
  assign hz.forwardBD = fwdBDS;
  assign hz.forwardAE = fwdAES;
  assign hz.forwardBE = fwdBES;
  assign hz.multbusy  = (stateR == BUSY);
  assign hz.multdone  = doneR;

`ifdef HAZARD_STALL_CNT_EN
  localparam logic [CNT_W-1:0] SCNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SCNT_ONE = CNT_W'(32'd1);
  logic [CNT_W-1:0] stallCntR;

  // Saturating count of cycles spent with Decode frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stallCntR <= {CNT_W{1'b0}};
    end else if (stallS && (stallCntR != SCNT_MAX)) begin
      stallCntR <= stallCntR + SCNT_ONE;
    end else begin
      stallCntR <= stallCntR;
    end
  end

  assign hz.stallcnt = stallCntR;
`else
  assign hz.stallcnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed cases, then random traffic against a
// cycle-arithmetic reference model.
module tb_hazard_ctrl;
  localparam int AW   = 5;
  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.AW(AW), .CNT_W(CW)) hz();

  hazard_ctrl #(.AW(AW), .MULT_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hz(hz)
  );

  typedef struct {
    int rsD, rtD, rsE, rtE, wE, wM, wW;
    bit rwE, rwM, rwW, mrE, mrM, br, mD, hD, ms;
  } stim_t;

  typedef struct {
    int cyc;
    bit stall;
    int fAE, fBE;
    bit fAD, fBD, busy, done;
    int scnt;
  } exp_t;

  exp_t sb[$];
  int nVec = 0;
  int nErr = 0;
  int cyc = 0;
  int mulEnd = -1000;  // cycle in which multdone is expected
  int mcnt = 0;

  task automatic chk(input string nm, input int c, input int act, input int want);
    nVec++;
    if (act != want) begin
      nErr++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, c, act, want);
    end
  endtask

  function automatic stim_t zs();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic int exSel(int src, int wM, bit rwM, int wW, bit rwW);
    if (src != 0 && rwM && src == wM) return 2;
    if (src != 0 && rwW && src == wW) return 1;
    return 0;
  endfunction

  // Drive one cycle of inputs, predict the outputs for that cycle, advance the model.
  task automatic step(input stim_t s, input bit rstn);
    exp_t e;
    bit busy, loadUse, branch, mult;
    @(posedge clk);
    #1;
    reset_n = rstn;
    hz.rsD = AW'(s.rsD); hz.rtD = AW'(s.rtD); hz.rsE = AW'(s.rsE); hz.rtE = AW'(s.rtE);
    hz.writeregE = AW'(s.wE); hz.writeregM = AW'(s.wM); hz.writeregW = AW'(s.wW);
    hz.regwriteE = s.rwE; hz.regwriteM = s.rwM; hz.regwriteW = s.rwW;
    hz.memtoregE = s.mrE; hz.memtoregM = s.mrM; hz.branchD = s.br;
    hz.multD = s.mD; hz.hiloreadD = s.hD; hz.multstartE = s.ms;
    cyc++;
    if (!rstn) begin
      mulEnd = -1000;
      mcnt = 0;
    end
    busy = rstn && (cyc > mulEnd - LAT) && (cyc < mulEnd);
    loadUse = s.mrE && s.rtE != 0 && (s.rtE == s.rsD || s.rtE == s.rtD);
    branch = s.br && ((s.rwE && s.wE != 0 && (s.wE == s.rsD || s.wE == s.rtD)) ||
                      (s.mrM && s.wM != 0 && (s.wM == s.rsD || s.wM == s.rtD)));
    mult = (s.mD || s.hD) && (busy || s.ms);
    e.cyc   = cyc;
    e.stall = rstn && (loadUse || branch || mult);
    e.fAE   = rstn ? exSel(s.rsE, s.wM, s.rwM, s.wW, s.rwW) : 0;
    e.fBE   = rstn ? exSel(s.rtE, s.wM, s.rwM, s.wW, s.rwW) : 0;
    e.fAD   = rstn && s.rsD != 0 && s.rwM && !s.mrM && s.rsD == s.wM;
    e.fBD   = rstn && s.rtD != 0 && s.rwM && !s.mrM && s.rtD == s.wM;
    e.busy  = busy;
    e.done  = rstn && (cyc == mulEnd);
    e.scnt  = mcnt;
    sb.push_back(e);
    if (rstn && s.ms && !busy) mulEnd = cyc + LAT;
    if (rstn && CNT_ON && e.stall && mcnt < CMAX) mcnt++;
  endtask

  // Immediate spot check a little after the inputs settle.
  task automatic probe(input string nm, input int act, input int want);
    chk(nm, cyc, act, want);
  endtask

  // Monitor: pops every predicted cycle and compares on the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stallF", e.cyc, int'(hz.stallF), int'(e.stall));
        chk("stallD", e.cyc, int'(hz.stallD), int'(e.stall));
        chk("flushE", e.cyc, int'(hz.flushE), int'(e.stall));
        chk("forwardAE", e.cyc, int'(hz.forwardAE), e.fAE);
        chk("forwardBE", e.cyc, int'(hz.forwardBE), e.fBE);
        chk("forwardAD", e.cyc, int'(hz.forwardAD), int'(e.fAD));
        chk("forwardBD", e.cyc, int'(hz.forwardBD), int'(e.fBD));
        chk("multbusy", e.cyc, int'(hz.multbusy), int'(e.busy));
        chk("multdone", e.cyc, int'(hz.multdone), int'(e.done));
        chk("stallcnt", e.cyc, int'(hz.stallcnt), e.scnt);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    s = zs();
    step(s, 1'b0);
    step(s, 1'b0);
    step(s, 1'b1);

    // Execute forwarding priority
    s = zs(); s.wM = 8; s.rwM = 1; s.wW = 8; s.rwW = 1; s.rsE = 8;
    step(s, 1'b1); #2 probe("fwdAE_mem", int'(hz.forwardAE), 2);
    s.rwM = 0;
    step(s, 1'b1); #2 probe("fwdAE_wb", int'(hz.forwardAE), 1);
    s.rsE = 0;
    step(s, 1'b1); #2 probe("fwdAE_zero", int'(hz.forwardAE), 0);

    // Load-use stall
    s = zs(); s.mrE = 1; s.rtE = 5; s.rsD = 5;
    step(s, 1'b1); #2 probe("loaduse", int'(hz.stallF), 1);
    s.rtE = 0; s.rsD = 0;
    step(s, 1'b1); #2 probe("loaduse_r0", int'(hz.flushE), 0);

    // Branch stall then Decode forwarding
    s = zs(); s.br = 1; s.rwE = 1; s.wE = 3; s.rtD = 3;
    step(s, 1'b1); #2 probe("branch_stall", int'(hz.stallD), 1);
    s.rwE = 0; s.wE = 0; s.wM = 3; s.rwM = 1; s.mrM = 0;
    step(s, 1'b1); #2 probe("branch_nostall", int'(hz.stallD), 0);
    probe("fwdBD", int'(hz.forwardBD), 1);

    // Multiply with hiloread held: busy 1..3, stall 0..3, done 4
    s = zs(); s.hD = 1;
    for (int i = 0; i < 6; i++) begin
      s.ms = (i == 0);
      step(s, 1'b1);
      #2;
      probe("mul_busy", int'(hz.multbusy), int'(i >= 1 && i <= 3));
      probe("mul_stall", int'(hz.stallD), int'(i <= 3));
      probe("mul_done", int'(hz.multdone), int'(i == 4));
    end

    // Back-to-back: restart in the done cycle
    s = zs(); s.ms = 1; step(s, 1'b1);
    s.ms = 0; repeat (3) step(s, 1'b1);
    s.ms = 1; step(s, 1'b1); #2 probe("b2b_done", int'(hz.multdone), 1);
    s.ms = 0; step(s, 1'b1); #2 probe("b2b_busy", int'(hz.multbusy), 1);
    repeat (4) step(s, 1'b1);

    // Reset in the middle of a multiply
    s = zs(); s.ms = 1; step(s, 1'b1);
    s.ms = 0; step(s, 1'b1);
    step(s, 1'b0); #2 probe("rst_busy", int'(hz.multbusy), 0);
    probe("rst_done", int'(hz.multdone), 0);
    probe("rst_cnt", int'(hz.stallcnt), 0);
    step(s, 1'b0);
    repeat (6) step(s, 1'b1);

    // Stall counter saturation
    s = zs(); s.mrE = 1; s.rtE = 5; s.rsD = 5;
    repeat (20) step(s, 1'b1);
    s = zs(); step(s, 1'b1); #2 probe("stallcnt_sat", int'(hz.stallcnt), CNT_ON ? 15 : 0);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      s.rsD = $urandom_range(0, 3); s.rtD = $urandom_range(0, 3);
      s.rsE = $urandom_range(0, 3); s.rtE = $urandom_range(0, 3);
      s.wE  = $urandom_range(0, 3); s.wM  = $urandom_range(0, 3);
      s.wW  = $urandom_range(0, 3);
      s.rwE = $urandom_range(0, 1) != 0; s.rwM = $urandom_range(0, 1) != 0;
      s.rwW = $urandom_range(0, 1) != 0; s.mrE = $urandom_range(0, 3) == 0;
      s.mrM = $urandom_range(0, 3) == 0; s.br  = $urandom_range(0, 2) == 0;
      s.mD  = $urandom_range(0, 3) == 0; s.hD  = $urandom_range(0, 3) == 0;
      s.ms  = $urandom_range(0, 4) == 0;
      step(s, $urandom_range(0, 99) != 0);
    end

    s = zs(); step(s, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", cyc, sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
